// File: rtl/chebyshev_coeff_sequencer.sv
// rtl/chebyshev_coeff_sequencer.sv - coefficient store and beat sequencer for the Chebyshev datapath
//
// Holds c[0..2^ORDER_WIDTH-1]. For each accepted sample x it streams c[N] down to c[0],
// one per cycle, alongside x. It then captures the datapath result and offers it
// on a valid/ready port.
//
// Ports:
//   clock, resetn                      clock, synchronous active-low reset
//   coeff_wr_en/addr/data, wr_ready    coefficient write port (accepted only in IDLE)
//   order, x_valid, x_data, x_ready    sample input; order sampled on the x handshake
//   cmp_valid/data/coeff/first/last    beat stream to the datapath (no backpressure)
//   cmp_result, cmp_result_valid       datapath result strobe (honoured only in WAIT)
//   y_data, y_valid, y_ready           result output
//   busy                               sequencer not idle
module chebyshev_coeff_sequencer #(
  parameter int WORD_LENGTH  = 16,
  parameter int COEFF_LENGTH = 16,
  parameter int ORDER_WIDTH  = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    coeff_wr_en,
  input  logic [ORDER_WIDTH-1:0]  coeff_wr_addr,
  input  logic [COEFF_LENGTH-1:0] coeff_wr_data,
  output logic                    coeff_wr_ready,
  input  logic [ORDER_WIDTH-1:0]  order,
  input  logic                    x_valid,
  input  logic [WORD_LENGTH-1:0]  x_data,
  output logic                    x_ready,
  output logic                    cmp_valid,
  output logic [WORD_LENGTH-1:0]  cmp_data,
  output logic [COEFF_LENGTH-1:0] cmp_coeff,
  output logic                    cmp_first,
  output logic                    cmp_last,
  input  logic [WORD_LENGTH-1:0]  cmp_result,
  input  logic                    cmp_result_valid,
  output logic [WORD_LENGTH-1:0]  y_data,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic                    busy
);

  localparam int DEPTH = 1 << ORDER_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ORDER_WIDTH-1:0]  idx;
  logic [ORDER_WIDTH-1:0]  idx_dec;
  logic [COEFF_LENGTH-1:0] mem [DEPTH];
  logic [COEFF_LENGTH-1:0] first_coeff;
  logic                    x_fire;
  logic                    wr_fire;

  // x_ready is a register that is low during reset and the cycle reset is
  // released, so both handshakes are gated by it rather than by state alone.
  assign coeff_wr_ready = x_ready;
  assign x_fire         = x_valid & x_ready;
  assign wr_fire        = coeff_wr_en & coeff_wr_ready;
  assign idx_dec        = idx - ORDER_WIDTH'(1);

  // A write landing on the same edge as the x handshake must be seen by the
  // first beat, which is loaded on that same edge.
  assign first_coeff = (wr_fire && (coeff_wr_addr == order)) ? coeff_wr_data : mem[order];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (x_fire) state_next = S_ISSUE;
      S_ISSUE:  if (idx == '0) state_next = S_WAIT;
      S_WAIT:   if (cmp_result_valid) state_next = S_OUTPUT;
      S_OUTPUT: if (y_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_ready   <= 1'b0;
      busy      <= 1'b0;
      cmp_valid <= 1'b0;
      y_valid   <= 1'b0;
      cmp_first <= 1'b0;
      cmp_last  <= 1'b0;
      cmp_data  <= '0;
      cmp_coeff <= '0;
      y_data    <= '0;
      idx       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      x_ready   <= (state_next == S_IDLE);
      busy      <= (state_next != S_IDLE);
      cmp_valid <= (state_next == S_ISSUE);
      y_valid   <= (state_next == S_OUTPUT);

      if (wr_fire) begin
        mem[coeff_wr_addr] <= coeff_wr_data;
      end

      case (state)
        S_IDLE: begin
          if (x_fire) begin
            cmp_data  <= x_data;
            idx       <= order;
            cmp_coeff <= first_coeff;
            cmp_first <= 1'b1;
            cmp_last  <= (order == '0);
          end
        end
        S_ISSUE: begin
          cmp_first <= 1'b0;
          if (idx != '0) begin
            // Memory cannot change here: writes are refused outside IDLE.
            idx       <= idx_dec;
            cmp_coeff <= mem[idx_dec];
            cmp_last  <= (idx_dec == '0);
          end else begin
            cmp_last <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cmp_result_valid) begin
            y_data <= cmp_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chebyshev_coeff_sequencer.sv
// tb/tb_chebyshev_coeff_sequencer.sv - self-checking bench for chebyshev_coeff_sequencer
module tb_chebyshev_coeff_sequencer;

  logic        clock;
  logic        resetn;
  logic        coeff_wr_en;
  logic [3:0]  coeff_wr_addr;
  logic [15:0] coeff_wr_data;
  logic        coeff_wr_ready;
  logic [3:0]  order;
  logic        x_valid;
  logic [15:0] x_data;
  logic        x_ready;
  logic        cmp_valid;
  logic [15:0] cmp_data;
  logic [15:0] cmp_coeff;
  logic        cmp_first;
  logic        cmp_last;
  logic [15:0] cmp_result;
  logic        cmp_result_valid;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_ready;
  logic        busy;

  chebyshev_coeff_sequencer #(
    .WORD_LENGTH(16),
    .COEFF_LENGTH(16),
    .ORDER_WIDTH(4)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .coeff_wr_en(coeff_wr_en),
    .coeff_wr_addr(coeff_wr_addr),
    .coeff_wr_data(coeff_wr_data),
    .coeff_wr_ready(coeff_wr_ready),
    .order(order),
    .x_valid(x_valid),
    .x_data(x_data),
    .x_ready(x_ready),
    .cmp_valid(cmp_valid),
    .cmp_data(cmp_data),
    .cmp_coeff(cmp_coeff),
    .cmp_first(cmp_first),
    .cmp_last(cmp_last),
    .cmp_result(cmp_result),
    .cmp_result_valid(cmp_result_valid),
    .y_data(y_data),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference coefficient memory: what every evaluation should stream.
  logic [15:0] model_c [16];

  typedef struct {
    logic [3:0]  ord;
    logic [15:0] x;
    logic [15:0] res;
    int          lat;
    int          yhold;
    int          exp_nb;
    logic [15:0] exp_first;
    logic [15:0] exp_y;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_coeff(input logic [3:0] a, input logic [15:0] d);
    chk("wr_ready_idle", coeff_wr_ready, 1);
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = a;
    coeff_wr_data = d;
    model_c[a]    = d;
    tick();
    coeff_wr_en = 1'b0;
  endtask

  task automatic run_eval(input logic [3:0] ord, input logic [15:0] x, input logic [15:0] res,
                          input int lat, input int yhold, input bit sim_wr,
                          input logic [3:0] sw_addr, input logic [15:0] sw_data,
                          input bit wr_issue, output int nbeats,
                          output logic [15:0] first_c, output logic [15:0] y_obs);
    int g;
    int k;
    g = 0;
    while (!x_ready && g < 50) begin
      tick();
      g++;
    end
    chk("x_ready_before_eval", x_ready, 1);
    if (sim_wr) begin
      coeff_wr_en   = 1'b1;
      coeff_wr_addr = sw_addr;
      coeff_wr_data = sw_data;
      model_c[sw_addr] = sw_data;
    end
    order   = ord;
    x_data  = x;
    x_valid = 1'b1;
    tick();
    x_valid     = 1'b0;
    coeff_wr_en = 1'b0;
    first_c     = 16'hxxxx;
    k = 0;
    while (cmp_valid && k <= 20) begin
      chk("beat_data", cmp_data, x);
      chk("beat_coeff", cmp_coeff, (k <= int'(ord)) ? model_c[int'(ord) - k] : 16'hxxxx);
      chk("beat_first", cmp_first, (k == 0));
      chk("beat_last", cmp_last, (k == int'(ord)));
      chk("beat_busy", busy, 1);
      chk("beat_wr_ready", coeff_wr_ready, 0);
      if (k == 0) first_c = cmp_coeff;
      if (wr_issue && k == 0) begin
        coeff_wr_en   = 1'b1;
        coeff_wr_addr = 4'd2;
        coeff_wr_data = 16'hFFFF;
      end else begin
        coeff_wr_en = 1'b0;
      end
      k++;
      tick();
    end
    coeff_wr_en = 1'b0;
    nbeats = k;
    chk("beat_count", k, int'(ord) + 1);
    chk("wait_cmp_valid", cmp_valid, 0);
    chk("wait_y_valid", y_valid, 0);
    chk("wait_busy", busy, 1);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("lat_cmp_valid", cmp_valid, 0);
      chk("lat_y_valid", y_valid, 0);
    end
    cmp_result       = res;
    cmp_result_valid = 1'b1;
    tick();
    cmp_result_valid = 1'b0;
    cmp_result       = 16'h0;
    for (int h = 0; h <= yhold; h++) begin
      chk("out_y_valid", y_valid, 1);
      chk("out_y_data", y_data, res);
      chk("out_x_ready", x_ready, 0);
      y_ready = (h == yhold);
      tick();
    end
    y_ready = 1'b0;
    y_obs = y_data;
    chk("post_x_ready", x_ready, 1);
    chk("post_y_valid", y_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [15:0] fc;
    logic [15:0] yo;

    tbl[0] = '{4'd3,  16'h1234, 16'h5A5A, 0, 5, 4,  16'd4,  16'h5A5A};
    tbl[1] = '{4'd0,  16'h00FF, 16'h0001, 2, 0, 1,  16'd1,  16'h0001};
    tbl[2] = '{4'd15, 16'hFFFF, 16'hBEEF, 1, 2, 16, 16'd16, 16'hBEEF};
    tbl[3] = '{4'd7,  16'h8000, 16'h0000, 3, 1, 8,  16'd8,  16'h0000};

    for (int i = 0; i < 16; i++) model_c[i] = 16'h0;
    resetn = 1'b0;
    coeff_wr_en = 1'b0; coeff_wr_addr = '0; coeff_wr_data = '0;
    order = '0; x_valid = 1'b0; x_data = '0;
    cmp_result = '0; cmp_result_valid = 1'b0; y_ready = 1'b0;

    tick();
    tick();
    chk("rst_x_ready", x_ready, 0);
    chk("rst_wr_ready", coeff_wr_ready, 0);
    chk("rst_cmp_valid", cmp_valid, 0);
    chk("rst_cmp_first", cmp_first, 0);
    chk("rst_cmp_last", cmp_last, 0);
    chk("rst_cmp_data", cmp_data, 0);
    chk("rst_cmp_coeff", cmp_coeff, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    tick();
    chk("rel_x_ready", x_ready, 1);
    chk("rel_wr_ready", coeff_wr_ready, 1);

    // c[i]=i+1 for i=0..3, order 3, x=0x1234
    for (int i = 0; i < 4; i++) write_coeff(4'(i), 16'(i + 1));
    run_eval(4'd3, 16'h1234, 16'h0C0C, 1, 0, 1'b0, 4'd0, 16'd0, 1'b0, nb, fc, yo);
    chk("plan_first_coeff", fc, 16'd4);

    // Table-driven evaluations over c[i]=i+1 for all i
    for (int i = 4; i < 16; i++) write_coeff(4'(i), 16'(i + 1));
    for (int v = 0; v < 4; v++) begin
      run_eval(tbl[v].ord, tbl[v].x, tbl[v].res, tbl[v].lat, tbl[v].yhold,
               1'b0, 4'd0, 16'd0, 1'b0, nb, fc, yo);
      chk("tbl_nbeats", nb, tbl[v].exp_nb);
      chk("tbl_first", fc, tbl[v].exp_first);
      chk("tbl_y", yo, tbl[v].exp_y);
    end

    // order 0 with c[0]=0x00AB
    write_coeff(4'd0, 16'h00AB);
    run_eval(4'd0, 16'h4444, 16'h7777, 2, 0, 1'b0, 4'd0, 16'd0, 1'b0, nb, fc, yo);
    chk("ord0_nbeats", nb, 1);
    chk("ord0_coeff", fc, 16'h00AB);

    // write attempt during ISSUE is refused; c[2] stays 3
    run_eval(4'd3, 16'h2222, 16'h3333, 0, 0, 1'b0, 4'd0, 16'd0, 1'b1, nb, fc, yo);
    run_eval(4'd2, 16'h5555, 16'h6666, 0, 0, 1'b0, 4'd0, 16'd0, 1'b0, nb, fc, yo);
    chk("c2_unchanged", fc, 16'd3);

    // stray result in IDLE
    cmp_result = 16'hDEAD;
    cmp_result_valid = 1'b1;
    tick();
    cmp_result_valid = 1'b0;
    tick();
    chk("stray_y_valid", y_valid, 0);
    chk("stray_y_data", y_data, 16'h6666);
    chk("stray_x_ready", x_ready, 1);

    // simultaneous write of c[3] and x handshake
    run_eval(4'd3, 16'h0101, 16'h0202, 0, 0, 1'b1, 4'd3, 16'h0077, 1'b0, nb, fc, yo);
    chk("sim_wr_first", fc, 16'h0077);

    // randomized evaluations against the model
    for (int r = 0; r < 30; r++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) write_coeff(4'($urandom_range(0, 15)), 16'($urandom));
      run_eval(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
               1'($urandom_range(0, 1)), nb, fc, yo);
    end

    // reset during ISSUE
    order = 4'd5; x_data = 16'h9999; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    tick();
    chk("pre_rst_cmp_valid", cmp_valid, 1);
    resetn = 1'b0;
    tick();
    chk("midrst_cmp_valid", cmp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmp_coeff", cmp_coeff, 0);
    chk("midrst_cmp_data", cmp_data, 0);
    chk("midrst_y_data", y_data, 0);
    chk("midrst_x_ready", x_ready, 0);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) model_c[i] = 16'h0;
    tick();
    cmp_result = 16'h1111;
    cmp_result_valid = 1'b1;
    tick();
    cmp_result_valid = 1'b0;
    tick();
    chk("postrst_y_valid", y_valid, 0);
    chk("postrst_y_data", y_data, 0);
    run_eval(4'd4, 16'hABCD, 16'h4321, 1, 1, 1'b0, 4'd0, 16'd0, 1'b0, nb, fc, yo);
    chk("postrst_first", fc, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
